// File: rtl/mux_rr_n.sv
// N-channel valid/ready multiplexer with fixed-select and round-robin arbitration
// feeding a single registered output stage.
module mux_rr_n #(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 4,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);

  logic [SELW-1:0]  ptr_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [SELW-1:0]  out_ch_r;

  logic             load_en_s;
  logic             grant_vld_s;
  logic [SELW-1:0]  grant_idx_s;
  logic [SELW-1:0]  cand_s;
  logic [NCH-1:0]   in_ready_s;

  // Output register may take a new word when empty or being drained this cycle.
  always_comb begin
    load_en_s = !out_valid_r || out_ready;
  end

  // Grant selection; the RR scan runs backwards so the earliest channel after ptr wins.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    if (mode) begin
      for (int k = NCH; k >= 1; k--) begin
        cand_s = ptr_r + SELW'(k);
        if (in_valid[cand_s]) begin
          grant_vld_s = 1'b1;
          grant_idx_s = cand_s;
        end else begin
          grant_vld_s = grant_vld_s;
        end
      end
    end else begin
      grant_vld_s = in_valid[sel];
      grant_idx_s = sel;
    end
  end

  // One-hot accept toward the granted channel; forced low while reset is asserted.
  always_comb begin
    in_ready_s = '0;
    if (rst_n && load_en_s && grant_vld_s) begin
      in_ready_s = NCH'(1) << grant_idx_s;
    end else begin
      in_ready_s = '0;
    end
  end

  assign in_ready = in_ready_s;

  // Output stage and round-robin pointer; ptr only advances on accepted RR transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_ch_r    <= '0;
      ptr_r       <= SELW'(NCH - 1);
    end else if (load_en_s) begin
      if (grant_vld_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= in_data[grant_idx_s*WIDTH +: WIDTH];
        out_ch_r    <= grant_idx_s;
        if (mode) begin
          ptr_r <= grant_idx_s;
        end else begin
          ptr_r <= ptr_r;
        end
      end else begin
        out_valid_r <= 1'b0;
      end
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;

endmodule

// File: doc/mux_rr_n.md
MUX_RR_N -- requirements
Module: mux_rr_n

Interface
Parameters:
REQ-001 WIDTH, default 8, data width per channel in bits; SHALL be >= 1.
REQ-002 NCH, default 4, number of input channels; SHALL be a power of two, >= 2.
REQ-003 SELW, default log2(NCH), select/channel-index width; SHALL be derived, not overridden.
Ports:
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  NCH  per-channel data-valid.
REQ-008 in_ready  output  NCH  per-channel accept; combinational, at most one bit high.
REQ-009 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-010 sel  input  SELW  channel index used in fixed mode; ignored in round-robin mode.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_valid  output  1  out_data holds an unconsumed word.
REQ-013 out_ready  input  1  downstream accept.
REQ-014 out_ch  output  SELW  registered index of the channel that supplied out_data.

Function
REQ-015 Output stage SHALL be one register; load_en = !out_valid || out_ready.
REQ-016 Transfer out SHALL occur on a cycle with out_valid && out_ready.
REQ-017 Grant SHALL be computed combinationally each cycle; in_ready[g] = load_en && granted(g); every other in_ready bit SHALL be 0.
REQ-018 Fixed mode: grant = sel if in_valid[sel]; otherwise no grant, even when other channels are valid.
REQ-019 Round-robin mode: search order SHALL be ptr+1, ptr+2, ... wrapping mod NCH, ending at ptr; grant = first channel with in_valid set.
REQ-020 ptr SHALL update to the granted index only on an accepted input transfer (in_valid[g] && in_ready[g]); it SHALL hold otherwise, including in fixed mode.
REQ-021 On an accepted input transfer: out_data <= channel g data, out_ch <= g, out_valid <= 1, all at the next rising edge (latency 1 cycle).
REQ-022 When load_en is 1 and there is no grant: out_valid <= 0; out_data and out_ch SHALL hold their previous values.
REQ-023 Stall (out_valid && !out_ready): out_data, out_ch and out_valid SHALL hold; all in_ready bits SHALL be 0.
REQ-024 Simultaneous consume and load SHALL sustain 1 word/cycle with no bubble.
REQ-025 A change to mode or sel SHALL affect only the next grant; a held output word SHALL be unaffected.
REQ-026 Round-robin fairness: with all NCH channels continuously valid and out_ready = 1, each channel SHALL be granted exactly once in every NCH consecutive grants.

Reset
REQ-027 When rst_n = 0, regardless of clk: out_valid = 0, out_data = 0, out_ch = 0, ptr = NCH-1, so the first round-robin search starts at channel 0.
REQ-028 Reset asserted mid-operation SHALL discard any held word; the first grant after reset release SHALL follow REQ-027 state.
REQ-029 in_ready SHALL be all-zero while rst_n = 0.

Verification (WIDTH=8, NCH=4)
REQ-030 Fixed mode: sel=2, in_valid=4'b1111, ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=A5, out_ch=2, out_valid=1.
REQ-031 Fixed mode: sel=1, in_valid=4'b1101 -> in_ready=0; after the current word drains, out_valid=0.
REQ-032 Round-robin from reset: in_valid=4'b1111 held, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles, with no bubbles.
REQ-033 Round-robin wrap with sparse channels: in_valid=4'b1001, ptr=3 -> grant 0, then 3, then 0.
REQ-034 Stall: out_ready=0 for 3 cycles with a word held -> out_data and out_ch stable and in_ready=0 throughout; then out_ready=1 -> the held word transfers and a new word loads in the same cycle.
REQ-035 Reset mid-stream: rst_n low between clock edges while out_valid=1 -> out_valid=0 immediately; after release with in_valid=4'b1111 -> first out_ch=0.
